uart_axi_bridge: RTL and testbench

Parametrised UART front end that replaces the CPU's inline polling loop: it polls an AXI4-Lite UART Lite slave (status/RX/TX registers), moves bytes into a receive FIFO and out of a transmit FIFO, and gives the CPU's in/out stage plain valid/ready byte streams. It generalises the earlier fixed 8-entry buffers to configurable depths. It adds three things the earlier loop lacked:
- round-robin RX/TX arbitration, so a busy receiver cannot starve transmit;
- correct full/empty detection at any depth;
- occupancy outputs.

---
 rtl/uart_bridge_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_axi_bridge.sv | 199 +++++++++++++++++++
 tb/tb_uart_axi_bridge.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Register map, status bit positions and FSM encoding shared by the UART AXI bridge.
package uart_bridge_pkg;

    localparam logic [7:0] UART_RX_ADDR   = 8'h00;
    localparam logic [7:0] UART_TX_ADDR   = 8'h04;
    localparam logic [7:0] UART_STAT_ADDR = 8'h08;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_FULL  = 3;

    localparam logic [3:0] AXI_WSTRB_ALL = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        ST_AR,
        ST_R,
        RX_AR,
        RX_R,
        TX_W,
        TX_B
    } bridge_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output and an explicit occupancy count.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    // The count is one bit wider than the pointers so full and empty stay distinct.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (DEPTH_LOG2 + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (DEPTH_LOG2 + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/uart_axi_bridge.sv
// Polls an AXI4-Lite UART Lite slave and exposes RX/TX byte streams backed by FIFOs.
// Optional macro UART_BRIDGE_ERR_EN: error responses drop RX bytes, retry TX bytes, set axi_err.
module uart_axi_bridge
    import uart_bridge_pkg::*;
#(
    parameter int RX_DEPTH_LOG2 = 3,
    parameter int TX_DEPTH_LOG2 = 3,
    parameter int ADDR_W        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDR_W-1:0]        m_axi_araddr,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    input  logic [31:0]              m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready,
    output logic [ADDR_W-1:0]        m_axi_awaddr,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [31:0]              m_axi_wdata,
    output logic [3:0]               m_axi_wstrb,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic [1:0]               m_axi_bresp,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    output logic                     rx_valid,
    output logic [7:0]               rx_data,
    input  logic                     rx_ready,
    input  logic                     tx_valid,
    input  logic [7:0]               tx_data,
    output logic                     tx_ready,
    output logic [RX_DEPTH_LOG2:0]   rx_count,
    output logic [TX_DEPTH_LOG2:0]   tx_count,
    output logic                     axi_err,
    output bridge_state_e            dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // valid never waits on ready and payload holds steady while valid is high.

    bridge_state_e state_q, state_d;
    logic          rr_q, rr_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          rx_push, tx_pop, err_set;
    logic          rx_full, rx_empty, tx_full, tx_empty;
    logic          rx_ok, tx_ok, rsp_ok_r, rsp_ok_b;
    logic [7:0]    tx_head;

    assign rx_ok = m_axi_rdata[STAT_RX_VALID] && !rx_full;
    assign tx_ok = !m_axi_rdata[STAT_TX_FULL] && !tx_empty;

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        rx_push       = 1'b0;
        tx_pop        = 1'b0;
        err_set       = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_awaddr  = '0;
        m_axi_awvalid = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        case (state_q)
            IDLE: state_d = ST_AR;
            ST_AR: begin
                m_axi_araddr  = ADDR_W'(UART_STAT_ADDR);
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = ST_R;
            end
            ST_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    // rr == 0 gives RX priority; it flips after each serviced direction.
                    if (rx_ok && (!tx_ok || !rr_q)) state_d = RX_AR;
                    else if (tx_ok)                 state_d = TX_W;
                    else                            state_d = IDLE;
                end
            end
            RX_AR: begin
                m_axi_araddr  = ADDR_W'(UART_RX_ADDR);
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = RX_R;
            end
            RX_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    rx_push = rsp_ok_r;
                    err_set = !rsp_ok_r;
                    rr_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            TX_W: begin
                m_axi_awaddr  = ADDR_W'(UART_TX_ADDR);
                m_axi_wdata   = {24'd0, tx_head};
                m_axi_awvalid = !aw_done_q;
                m_axi_wvalid  = !w_done_q;
                aw_done_d     = aw_done_q | m_axi_awready;
                w_done_d      = w_done_q | m_axi_wready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = TX_B;
                end
            end
            TX_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    tx_pop  = rsp_ok_b;
                    err_set = !rsp_ok_b;
                    rr_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

`ifdef UART_BRIDGE_ERR_EN
    logic axi_err_q, axi_err_d;

    assign rsp_ok_r = (m_axi_rresp == 2'b00);
    assign rsp_ok_b = (m_axi_bresp == 2'b00);

    always_comb begin
        axi_err_d = axi_err_q | err_set;
    end

    always_ff @(posedge clk) begin
        if (rst) axi_err_q <= 1'b0;
        else     axi_err_q <= axi_err_d;
    end

    assign axi_err = axi_err_q;
`else
    logic unused_resp;

    assign rsp_ok_r    = 1'b1;
    assign rsp_ok_b    = 1'b1;
    assign axi_err     = 1'b0;
    assign unused_resp = ^{m_axi_rresp, m_axi_bresp, err_set};
`endif

    logic unused_rdata;
    assign unused_rdata = ^m_axi_rdata[31:8];

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (m_axi_rdata[7:0]),
        .pop   (rx_valid && rx_ready),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid && tx_ready),
        .din   (tx_data),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign rx_valid    = !rx_empty;
    assign tx_ready    = !tx_full;
    assign m_axi_wstrb = AXI_WSTRB_ALL;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_axi_bridge.sv
// Directed bench for uart_axi_bridge: zero-wait UART Lite slave model plus byte scoreboards.
module tb_uart_axi_bridge;
    import uart_bridge_pkg::*;

`ifdef UART_BRIDGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk, rst;
    logic [3:0]  m_axi_araddr, m_axi_awaddr;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_rdata, m_axi_wdata;
    logic [1:0]  m_axi_rresp, m_axi_bresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid, m_axi_bready;
    logic        rx_valid, rx_ready, tx_valid, tx_ready, axi_err;
    logic [7:0]  rx_data, tx_data;
    logic [3:0]  rx_count;
    logic [2:0]  tx_count;
    bridge_state_e dbg_state;

    uart_axi_bridge #(.RX_DEPTH_LOG2(3), .TX_DEPTH_LOG2(2), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_count(rx_count), .tx_count(tx_count), .axi_err(axi_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- UART Lite slave model ----------------
    logic [7:0] stat_val, rx_base, rx_byte;
    logic       hold, w_slow, err_first, cyc;
    logic       rd_pend, aw_got, w_got, b_pend;
    logic [3:0] rd_addr;
    int         rx_reads, stat_reads, aw_count, b_count;
    logic       aw_hs, w_hs;

    assign m_axi_arready = 1'b1;
    assign m_axi_rvalid  = rd_pend;
    assign m_axi_rresp   = 2'b00;
    assign m_axi_awready = !hold && !aw_got;
    assign m_axi_wready  = !hold && !w_got && (!w_slow || cyc);
    assign m_axi_bvalid  = b_pend;
    assign m_axi_bresp   = (err_first && b_count == 0) ? 2'b10 : 2'b00;
    assign aw_hs         = m_axi_awvalid && m_axi_awready;
    assign w_hs          = m_axi_wvalid && m_axi_wready;

    always_comb begin
        m_axi_rdata = 32'd0;
        if (rd_addr == 4'h8)      m_axi_rdata = {24'd0, stat_val};
        else if (rd_addr == 4'h0) m_axi_rdata = {24'd0, rx_byte};
    end

    always @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
            rd_addr <= 4'hF; rx_byte <= rx_base; cyc <= 1'b0;
            rx_reads <= 0; stat_reads <= 0; aw_count <= 0; b_count <= 0;
        end else begin
            cyc <= ~cyc;
            if (m_axi_arvalid && m_axi_arready) begin
                rd_pend <= 1'b1;
                rd_addr <= m_axi_araddr;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                rd_pend <= 1'b0;
                if (rd_addr == 4'h0) begin
                    rx_byte  <= rx_byte + 8'd1;
                    rx_reads <= rx_reads + 1;
                end
                if (rd_addr == 4'h8) stat_reads <= stat_reads + 1;
            end
            if (aw_hs) begin
                aw_got   <= 1'b1;
                aw_count <= aw_count + 1;
            end
            if (w_hs) w_got <= 1'b1;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                b_pend <= 1'b1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_pend  <= 1'b0;
                b_count <= b_count + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int         checks, errors;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_wr_q[$];
    int         w_rx_reads[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (!rst) begin
            if (rx_valid && rx_ready) begin
                if (exp_rx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_data);
                end else begin
                    e = exp_rx_q.pop_front();
                    check("rx_byte", 32'(rx_data), 32'(e));
                end
            end
            if (w_hs) begin
                w_rx_reads.push_back(rx_reads);
                if (exp_wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got %0h expected none", m_axi_wdata);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wdata", m_axi_wdata, {24'd0, e});
                end
            end
            if (aw_hs) begin
                check("awaddr", 32'(m_axi_awaddr), 32'h4);
                check("wstrb", 32'(m_axi_wstrb), 32'hF);
            end
            if (m_axi_arvalid && m_axi_arready)
                check("araddr_legal", 32'(m_axi_araddr == 4'h0 || m_axi_araddr == 4'h8), 32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1; tx_valid = 1'b0; rx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_valid = 1'b1; tx_data = b;
        for (int i = 0; i < 100 && !tx_ready; i++) begin
            @(posedge clk); #1;
        end
        check("push_ready", 32'(tx_ready), 32'd1);
        exp_wr_q.push_back(b);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_tx_drain(input string name);
        for (int i = 0; i < 300 && tx_count != 0; i++) @(negedge clk);
        check(name, 32'(tx_count), 32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int sr0;
        checks = 0; errors = 0;
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        stat_val = 8'h00; rx_base = 8'h10; hold = 1'b0; w_slow = 1'b0; err_first = 1'b0;

        // Reset values, then the first status poll.
        do_reset();
        check("rst_valids", 32'({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'd0);
        check("rst_addrs", 32'({m_axi_araddr, m_axi_awaddr}), 32'd0);
        check("rst_wdata", m_axi_wdata, 32'd0);
        check("rst_wstrb", 32'(m_axi_wstrb), 32'hF);
        check("rst_fifo", 32'({rx_valid, tx_ready, rx_count, tx_count}), 32'({1'b0, 1'b1, 4'd0, 3'd0}));
        check("rst_err", 32'(axi_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk); #1;
        check("poll_ar", 32'({m_axi_arvalid, m_axi_araddr}), 32'({1'b1, 4'h8}));

        // Reset while a TX write is stalled in TX_W.
        hold = 1'b1;
        tx_valid = 1'b1; tx_data = 8'h55;
        @(posedge clk); #1; tx_valid = 1'b0;
        for (int i = 0; i < 20 && dbg_state != TX_W; i++) begin
            @(posedge clk); #1;
        end
        check("midtx_awvalid", 32'(m_axi_awvalid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valids", 32'({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'd0);
        check("midrst_txcount", 32'(tx_count), 32'd0);
        check("midrst_txready", 32'(tx_ready), 32'd1);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        hold = 1'b0;

        // RX fill + fairness: status 0x01, two TX bytes, RX not drained.
        stat_val = 8'h01; rx_base = 8'h10;
        do_reset();
        w_rx_reads.delete();
        tx_valid = 1'b1; tx_data = 8'hA5; exp_wr_q.push_back(8'hA5);
        @(posedge clk); #1;
        tx_data = 8'h5A; exp_wr_q.push_back(8'h5A);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dbg_state == RX_R && m_axi_rvalid) break;
        end
        check("rx_lat_before", 32'(rx_valid), 32'd0);
        @(negedge clk);
        check("rx_lat_after", 32'({rx_valid, rx_data}), 32'({1'b1, 8'h10}));
        for (int i = 0; i < 100 && !(aw_count == 2 && tx_count == 0); i++) @(negedge clk);
        check("fair_writes", 32'(w_rx_reads.size()), 32'd2);
        if (w_rx_reads.size() >= 2) begin
            check("fair_rx_before_a5", 32'(w_rx_reads[0]), 32'd1);
            check("fair_rx_between", 32'(w_rx_reads[1] - w_rx_reads[0]), 32'd1);
        end
        for (int i = 0; i < 200 && rx_count != 4'd8; i++) @(negedge clk);
        check("rx_fill_count", 32'(rx_count), 32'd8);
        sr0 = stat_reads;
        repeat (40) @(negedge clk);
        check("rx_full_no_read", 32'(rx_reads), 32'd8);
        check("rx_full_polls", 32'(stat_reads - sr0 >= 5), 32'd1);
        for (int b = 0; b < 8; b++) exp_rx_q.push_back(8'(8'h10 + b));
        @(posedge clk); #1;
        stat_val = 8'h00;
        repeat (5) @(posedge clk);
        #1 rx_ready = 1'b1;
        for (int i = 0; i < 50 && rx_count != 0; i++) @(negedge clk);
        @(posedge clk); #1 rx_ready = 1'b0;
        check("rx_drained", 32'(exp_rx_q.size()), 32'd0);

        // TX backpressure, with W ready alternating so AW and W complete in either order.
        stat_val = 8'h08; w_slow = 1'b1;
        do_reset();
        push_tx(8'h61); push_tx(8'h62); push_tx(8'h63);
        repeat (30) @(posedge clk);
        #1;
        check("bp_no_aw", 32'(aw_count), 32'd0);
        check("bp_count", 32'(tx_count), 32'd3);
        stat_val = 8'h00;
        wait_tx_drain("bp_drain");
        repeat (5) @(negedge clk);
        check("bp_writes", 32'(aw_count), 32'd3);
        @(posedge clk); #1 w_slow = 1'b0;

        // Push and pop in the same cycle across the pointer wrap, then fill to 4.
        stat_val = 8'h08;
        do_reset();
        push_tx(8'h71); push_tx(8'h72); push_tx(8'h73);
        check("wrap_pre", 32'(tx_count), 32'd3);
        stat_val = 8'h00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_axi_bready && m_axi_bvalid) break;
        end
        tx_valid = 1'b1; tx_data = 8'h74; exp_wr_q.push_back(8'h74);
        @(posedge clk); #1;
        check("wrap_pushpop_count", 32'(tx_count), 32'd3);
        check("wrap_pushpop_ready", 32'(tx_ready), 32'd1);
        tx_data = 8'h75; exp_wr_q.push_back(8'h75);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check("wrap_full_count", 32'(tx_count), 32'd4);
        check("wrap_full_ready", 32'(tx_ready), 32'd0);
        wait_tx_drain("wrap_drain");
        repeat (5) @(negedge clk);

        // Error response on the write of 0x41.
        stat_val = 8'h00; err_first = 1'b1;
        do_reset();
        push_tx(8'h41);
        if (ERR_EN) exp_wr_q.push_back(8'h41);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (b_count == 1) break;
        end
        check("err_flag", 32'(axi_err), ERR_EN ? 32'd1 : 32'd0);
        check("err_txcount", 32'(tx_count), ERR_EN ? 32'd1 : 32'd0);
        wait_tx_drain("err_drain");
        repeat (10) @(negedge clk);
        check("err_writes", 32'(aw_count), ERR_EN ? 32'd2 : 32'd1);
        check("err_sticky", 32'(axi_err), ERR_EN ? 32'd1 : 32'd0);
        @(posedge clk); #1 err_first = 1'b0;

        check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
        check("rx_queue_empty", 32'(exp_rx_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
